prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Writer side of the instruction-memory interface. Receives a program as a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into instruction memory from address 0. Holds the CPU while a load is in progress, then reports done or error. Sits between a host/UART byte source and the instruction memory write port, alongside the CPU's fetch path.

Parameters:
ADDR_W, 10, instruction memory address width
DATA_W, 16, instruction word width (fixed at 2 bytes; other values unsupported)
DEPTH, 1024, maximum words accepted (must be at most 2**ADDR_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a load; sampled only in IDLE
in_valid  in  1  byte source has data
in_data  in  8  byte from source
in_ready  out  1  loader accepts byte this cycle
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  ADDR_W  write address, valid when imem_we=1
imem_wdata  out  DATA_W  write data, valid when imem_we=1
cpu_hold  out  1  CPU must stay in reset/stall while 1
done  out  1  one-cycle pulse on successful load
err  out  1  sticky error flag
words_loaded  out  ADDR_W+1  words written by last load

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; in_ready, imem_we, cpu_hold, done, err=0; imem_addr, imem_wdata, words_loaded=0. rst mid-load aborts immediately; no further writes; words already written stay in memory.
- A byte is accepted on a rising edge where in_valid & in_ready. in_ready depends only on state, never on in_valid.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then N words as HI byte then LO byte, then one checksum byte = XOR of all 2N data bytes (length bytes excluded).
- FSM states: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE.
- IDLE: in_ready=0. start=1 -> LEN_HI, cpu_hold<=1, err<=0, index<=0, chk<=0. start in any other state is ignored.
- LEN_HI / LEN_LO: in_ready=1; capture len[15:8] / len[7:0]. After LEN_LO: N==0 or N>DEPTH -> err<=1, cpu_hold<=0, IDLE; else DAT_HI.
- DAT_HI / DAT_LO: in_ready=1; capture byte into word_hi / word_lo; chk ^= byte. After DAT_LO -> WRITE.
- WRITE: in_ready=0; imem_we=1 for exactly this cycle, imem_addr=index, imem_wdata={hi,lo}. index++. If index+1==N -> CHK, else DAT_HI.
- CHK: in_ready=1; byte==chk -> DONE; mismatch -> err<=1, cpu_hold<=0, words_loaded<=N, IDLE.
- DONE: done=1 for one cycle, cpu_hold<=0, words_loaded<=N, -> IDLE.
- Throughput: minimum 3 cycles per word (HI, LO, WRITE), with no stalls when in_valid stays high. in_valid gaps stall any accepting state indefinitely, with no timeout.
- Index wrap cannot occur: N<=DEPTH is enforced before any write.
- imem_we is never asserted outside WRITE. err holds until the next accepted start or rst.

Decomposition:
- Shared package: state encoding localparams (3-bit), frame constants (LEN_BYTES=2, CHK_BYTES=1), default ADDR_W/DEPTH matching the CPU's PC width.
- Single module; no sub-module is natural. The byte-assembly and checksum logic is a few registers inside the FSM.

Test Plan:
- Nominal: start; stream 00 03 12 34 AB CD 00 FF BF, in_valid held high -> writes (0,1234),(1,ABCD),(2,00FF) on three single-cycle imem_we pulses 3 cycles apart; done pulses once; words_loaded=3; cpu_hold high from the cycle after start until DONE.
- Zero/over length: stream 00 00 -> err=1, no imem_we, cpu_hold drops. Stream 04 01 with DEPTH=1024 -> err=1, no writes.
- Bad checksum: 00 01 12 34 00 -> one write (0,1234), then err=1, done never pulses.
- Backpressure/gaps: nominal frame with in_valid toggled randomly -> identical writes and order. No byte is accepted during WRITE (in_ready=0 there).
- Reset mid-load: rst asserted after the second data word is written -> next cycle IDLE, all outputs 0, no further imem_we. A following fresh start loads correctly.
- start ignored while busy: pulse start during DAT_LO -> no restart; load completes normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prog_loader_pkg;

  // Defaults match the CPU program counter width and instruction memory size.
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;

  // Frame overhead: two big-endian length bytes up front, one XOR byte at the end.
  localparam int LEN_BYTES = 2;
  localparam int CHK_BYTES = 1;

  // 3-bit loader state encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DAT_HI = 3'd3;
  localparam logic [2:0] ST_DAT_LO = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_CHK    = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LEN_HI = ST_LEN_HI,
    S_LEN_LO = ST_LEN_LO,
    S_DAT_HI = ST_DAT_HI,
    S_DAT_LO = ST_DAT_LO,
    S_WRITE  = ST_WRITE,
    S_CHK    = ST_CHK,
    S_DONE   = ST_DONE
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// Program loader: byte stream (len, HI/LO word pairs, XOR checksum) -> sequential imem writes from address 0.
// Latency: a word is written 1 cycle after its LO byte is accepted; 3 cycles/word minimum.
// Backpressure: in_ready is a pure function of state (low in IDLE/WRITE/DONE); in_valid gaps stall indefinitely.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a load (honoured only in IDLE)
//   in_valid/in_ready    : byte handshake, in_data carries the byte
//   imem_we/addr/wdata   : instruction memory write port, one strobe per word
//   cpu_hold             : keeps the CPU stalled for the duration of a load
//   done / err           : success pulse / sticky failure flag (cleared by next start)
//   words_loaded         : word count N of the last frame that reached its checksum
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // One extra bit so an index/count equal to DEPTH (= 2**ADDR_W) is representable.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [7:0]       word_hi_q, word_hi_d;
  logic [7:0]       word_lo_q, word_lo_d;
  logic [7:0]       chk_q, chk_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] words_loaded_q, words_loaded_d;

  logic [15:0]      n_len;
  logic [IDX_W-1:0] index_inc;

  // Full word count as it stands on the edge the LEN_LO byte is accepted.
  assign n_len     = {len_hi_q, in_data};
  assign index_inc = index_q + IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    len_hi_d       = len_hi_q;
    len_d          = len_q;
    word_hi_d      = word_hi_q;
    word_lo_d      = word_lo_q;
    chk_d          = chk_q;
    index_d        = index_q;
    cpu_hold_d     = cpu_hold_q;
    err_d          = err_q;
    words_loaded_d = words_loaded_q;
    in_ready       = 1'b0;
    imem_we        = 1'b0;
    imem_addr      = '0;
    imem_wdata     = '0;
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN_HI;
          cpu_hold_d = 1'b1;
          err_d      = 1'b0;
          index_d    = '0;
          chk_d      = '0;
        end
      end

      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Reject empty frames and frames that would overrun memory before any write.
          if (n_len == 16'd0 || {1'b0, n_len} > DEPTH_L) begin
            err_d      = 1'b1;
            cpu_hold_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            len_d   = n_len[IDX_W-1:0];
            state_d = S_DAT_HI;
          end
        end
      end

      S_DAT_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_hi_d = in_data;
          chk_d     = chk_q ^ in_data;
          state_d   = S_DAT_LO;
        end
      end

      S_DAT_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_lo_d = in_data;
          chk_d     = chk_q ^ in_data;
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = index_q[ADDR_W-1:0];
        imem_wdata = {word_hi_q, word_lo_q};
        index_d    = index_inc;
        state_d    = (index_inc == len_q) ? S_CHK : S_DAT_HI;
      end

      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
          end else begin
            err_d          = 1'b1;
            cpu_hold_d     = 1'b0;
            words_loaded_d = len_q;
            state_d        = S_IDLE;
          end
        end
      end

      S_DONE: begin
        done           = 1'b1;
        cpu_hold_d     = 1'b0;
        words_loaded_d = len_q;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_hi_q       <= '0;
      len_q          <= '0;
      word_hi_q      <= '0;
      word_lo_q      <= '0;
      chk_q          <= '0;
      index_q        <= '0;
      cpu_hold_q     <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      len_hi_q       <= len_hi_d;
      len_q          <= len_d;
      word_hi_q      <= word_hi_d;
      word_lo_q      <= word_lo_d;
      chk_q          <= chk_d;
      index_q        <= index_d;
      cpu_hold_q     <= cpu_hold_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign cpu_hold     = cpu_hold_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames in, expected imem writes queued, monitor pops on each imem_we.
// Latency: n/a.
// Backpressure: driver waits on in_ready with a bounded cycle budget.
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  last_we     = -1;
  int  done_seen   = 0;
  bit  chk_spacing = 1'b0;
  wr_t exp_q[$];

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (imem_we) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_write: in_ready=%b required 0", in_ready);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          miscompares++;
          $display("FAIL write: got (%h,%h) required (%h,%h)", imem_addr, imem_wdata, e.addr, e.data);
        end
      end
      if (chk_spacing && last_we >= 0) begin
        vectors++;
        if (cyc - last_we != 3) begin
          miscompares++;
          $display("FAIL write_spacing: got %0d cycles required 3", cyc - last_we);
        end
      end
      last_we = cyc;
    end
    if (done) done_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic do_start();
    last_we   = -1;
    done_seen = 0;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("err_cleared_by_start", {31'd0, err}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      tick(gap);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: in_ready=0 for %0d cycles required 1", t);
    end else begin
      tick(1);
    end
  endtask

  // start_at: byte index during which start is held high (-1 for none).
  task automatic send_frame(input bq_t bytes, input bit gaps, input int start_at);
    for (int i = 0; i < bytes.size(); i++) begin
      start = (i == start_at);
      send_byte(bytes[i], gaps ? int'($urandom_range(0, 3)) : 0);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic expect_ok(input string tag, input int n);
    tick(3);
    check({tag, "_done_count"}, done_seen, 32'd1);
    check({tag, "_writes_pending"}, exp_q.size(), 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_words_loaded"}, {21'd0, words_loaded}, n);
  endtask

  task automatic expect_err(input string tag);
    tick(3);
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done_count"}, done_seen, 32'd0);
    check({tag, "_writes_pending"}, exp_q.size(), 32'd0);
    check({tag, "_ready_idle"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_addr"}, {22'd0, imem_addr}, 32'd0);
    check({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
    check({tag, "_words_loaded"}, {21'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    bq_t nominal;
    bq_t frame;
    nominal  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBF};
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Nominal load, in_valid held high: writes exactly 3 cycles apart.
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    push_wr(10'd2, 16'h00FF);
    do_start();
    chk_spacing = 1'b1;
    send_frame(nominal, 1'b0, -1);
    check("nominal_done_pulse", {31'd0, done}, 32'd1);
    check("nominal_hold_in_done", {31'd0, cpu_hold}, 32'd1);
    chk_spacing = 1'b0;
    expect_ok("nominal", 3);

    // Zero-length frame.
    do_start();
    frame = '{8'h00, 8'h00};
    send_frame(frame, 1'b0, -1);
    expect_err("zero_len");

    // Over-length frame: 0x0401 = 1025 > 1024.
    do_start();
    frame = '{8'h04, 8'h01};
    send_frame(frame, 1'b0, -1);
    expect_err("over_len");

    // Bad checksum: one word written, then error.
    push_wr(10'd0, 16'h1234);
    do_start();
    frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    send_frame(frame, 1'b0, -1);
    expect_err("bad_chk");
    check("bad_chk_words_loaded", {21'd0, words_loaded}, 32'd1);

    // Nominal frame with random in_valid gaps.
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    push_wr(10'd2, 16'h00FF);
    do_start();
    send_frame(nominal, 1'b1, -1);
    expect_ok("gaps", 3);

    // Reset after the second word is written.
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    do_start();
    frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_frame(frame, 1'b0, -1);
    tick(1);
    check("midrst_writes_pending", exp_q.size(), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    rst      = 1'b1;
    tick(1);
    check_all_zero("midrst");
    rst = 1'b0;
    tick(4);
    in_valid = 1'b0;
    check("midrst_idle_hold", {31'd0, cpu_hold}, 32'd0);
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    push_wr(10'd2, 16'h00FF);
    do_start();
    send_frame(nominal, 1'b0, -1);
    expect_ok("after_rst", 3);

    // start pulsed while the DAT_LO byte (0x22) is presented must be ignored.
    push_wr(10'd0, 16'h1122);
    push_wr(10'd1, 16'h3344);
    do_start();
    frame = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(frame, 1'b0, 3);
    expect_ok("start_ignored", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
